// File: rtl/lca_pkg.sv
// Shared defaults and sizing helpers for the latency credit adapter.
package lca_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_DEPTH   = 6;

  // Bits needed to hold a count in 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/lca_fifo.sv
// Synchronous result FIFO with registered pointers that wrap modulo DEPTH.
module lca_fifo
  import lca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = credit_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_rd   = rd_en && (count != '0);
  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr && !reset) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/latency_credit_adapter.sv
// Credit-based valid/ready wrapper around a fixed-latency no-stall pipe.
// Define LATENCY_CREDIT_ADAPTER_PERF_EN to add the perf_stall_cnt output.
module latency_credit_adapter
  import lca_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] pipe_in1,
  output logic [WIDTH-1:0] pipe_in2,
  input  logic [WIDTH-1:0] pipe_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);
  localparam int CW = credit_w(DEPTH);

  logic [CW-1:0]    credits;
  logic [CW-1:0]    fifo_count;
  logic [LATENCY:1] vld_pipe;
  logic             issue, pop;

  assign pipe_in1  = in_a;
  assign pipe_in2  = in_b;
  // Credits cover both in-flight tags and stored results, so the FIFO cannot overflow.
  assign in_ready  = (credits != '0);
  assign issue     = in_valid && in_ready && !reset;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      credits  <= CW'(DEPTH);
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:1], issue};
      case ({issue, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  lca_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (vld_pipe[LATENCY]),
    .wr_data (pipe_out),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (fifo_count)
  );

`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
  always_ff @(posedge clock) begin
    if (reset)
      perf_stall_cnt <= '0;
    else if (in_valid && !in_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_latency_credit_adapter.sv
// Randomized bench: two adapters (default and DEPTH=1/LATENCY=2) checked against a queue model.
module tb_latency_credit_adapter;
  localparam int LA = 4, DA = 6, LB = 2, DB = 1;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_in_a = 0, a_in_b = 0, a_pipe_in1, a_pipe_in2, a_pipe_out, a_out_data;
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [31:0] b_in_a = 0, b_in_b = 0, b_pipe_in1, b_pipe_in2, b_pipe_out, b_out_data;
`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
  logic [31:0] a_perf, b_perf;
`endif

  latency_credit_adapter #(.WIDTH(32), .LATENCY(LA), .DEPTH(DA)) dut_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .pipe_in1(a_pipe_in1), .pipe_in2(a_pipe_in2),
    .pipe_out(a_pipe_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data)
`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
    , .perf_stall_cnt(a_perf)
`endif
  );

  latency_credit_adapter #(.WIDTH(32), .LATENCY(LB), .DEPTH(DB)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .pipe_in1(b_pipe_in1), .pipe_in2(b_pipe_in2),
    .pipe_out(b_pipe_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data)
`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
    , .perf_stall_cnt(b_perf)
`endif
  );

  // Attached pipes: result = in1 + in2, exactly L cycles after presentation.
  logic [31:0] a_hist [LA];
  logic [31:0] b_hist [LB];
  always @(posedge clock) begin
    a_hist[0] <= a_pipe_in1 + a_pipe_in2;
    for (int i = 1; i < LA; i++) a_hist[i] <= a_hist[i-1];
    b_hist[0] <= b_pipe_in1 + b_pipe_in2;
    for (int i = 1; i < LB; i++) b_hist[i] <= b_hist[i-1];
  end
  assign a_pipe_out = a_hist[LA-1];
  assign b_pipe_out = b_hist[LB-1];

  // Reference model: ordered queue of (value, issue cycle) plus issue/pop totals.
  logic [31:0] aq[$], bq[$];
  int          at[$], bt[$];
  int          a_iss, a_pop, b_iss, b_pop, stall;
  int          vectors = 0, errors = 0;

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1; a_in_valid = 1; b_in_valid = 1;
    repeat (n) @(negedge clock);
    reset = 0; a_in_valid = 0; b_in_valid = 0;
    aq.delete(); at.delete(); bq.delete(); bt.delete();
    a_iss = 0; a_pop = 0; b_iss = 0; b_pop = 0; stall = 0;
  endtask

  // One cycle: drive, sample #1 after the falling edge, advance the model.
  task automatic step(input int sel, input logic iv, input logic ordy,
                      output logic e_rdy, output logic a_rdy,
                      output logic e_ov, output logic a_ov,
                      output logic [31:0] e_d, output logic [31:0] a_d);
    logic [31:0] x, y;
    @(negedge clock);
    x = $urandom; y = $urandom;
    if (sel == 0) begin
      a_in_valid = iv; a_out_ready = ordy; a_in_a = x; a_in_b = y;
      #1;
      e_rdy = (a_iss - a_pop) < DA;
      e_ov  = (aq.size() != 0) && (at[0] + LA + 1 <= cyc);
      e_d   = e_ov ? aq[0] : '0;
      a_rdy = a_in_ready; a_ov = a_out_valid; a_d = a_out_data;
      if (iv && !e_rdy) stall++;
      if (iv && e_rdy) begin aq.push_back(x + y); at.push_back(cyc); a_iss++; end
      if (e_ov && ordy) begin void'(aq.pop_front()); void'(at.pop_front()); a_pop++; end
    end else begin
      b_in_valid = iv; b_out_ready = ordy; b_in_a = x; b_in_b = y;
      #1;
      e_rdy = (b_iss - b_pop) < DB;
      e_ov  = (bq.size() != 0) && (bt[0] + LB + 1 <= cyc);
      e_d   = e_ov ? bq[0] : '0;
      a_rdy = b_in_ready; a_ov = b_out_valid; a_d = b_out_data;
      if (iv && e_rdy) begin bq.push_back(x + y); bt.push_back(cyc); b_iss++; end
      if (e_ov && ordy) begin void'(bq.pop_front()); void'(bt.pop_front()); b_pop++; end
    end
  endtask

  logic        er, ar, eo, ao;
  logic [31:0] ed, ad;

  task automatic test_reset();
    do_reset(3);
    step(0, 1'b0, 1'b0, er, ar, eo, ao, ed, ad);
    vectors++; if (ar !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", ar); end
    vectors++; if (ao !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b exp 0", ao); end
    step(1, 1'b0, 1'b0, er, ar, eo, ao, ed, ad);
    vectors++; if (ar !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b exp 1", ar); end
    vectors++; if (ao !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b exp 0", ao); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 9; i++) begin
      step(0, i == 0, 1'b1, er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== er) begin errors++; $display("FAIL single_ready cyc=%0d got %b exp %b", i, ar, er); end
      vectors++; if (ao !== eo) begin errors++; $display("FAIL single_valid cyc=%0d got %b exp %b", i, ao, eo); end
      if (eo) begin vectors++; if (ad !== ed) begin errors++; $display("FAIL single_data cyc=%0d got %h exp %h", i, ad, ed); end end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 110; i++) begin
      step(0, i < 100, 1'b1, er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== er) begin errors++; $display("FAIL stream_ready i=%0d got %b exp %b", i, ar, er); end
      vectors++; if (ao !== eo) begin errors++; $display("FAIL stream_valid i=%0d got %b exp %b", i, ao, eo); end
      if (eo) begin vectors++; if (ad !== ed) begin errors++; $display("FAIL stream_data i=%0d got %h exp %h", i, ad, ed); end end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, 1'b0, er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== er) begin errors++; $display("FAIL bp_ready i=%0d got %b exp %b", i, ar, er); end
      vectors++; if (ao !== eo) begin errors++; $display("FAIL bp_valid i=%0d got %b exp %b", i, ao, eo); end
    end
`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
    @(negedge clock); a_in_valid = 0; a_out_ready = 0; #1;
    vectors++; if (a_perf !== 32'(stall)) begin errors++; $display("FAIL perf_stall got %0d exp %0d", a_perf, stall); end
`endif
    for (int i = 0; i < 32; i++) begin
      step(0, i < 20, 1'b1, er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== er) begin errors++; $display("FAIL bp_rel_ready i=%0d got %b exp %b", i, ar, er); end
      vectors++; if (ao !== eo) begin errors++; $display("FAIL bp_rel_valid i=%0d got %b exp %b", i, ao, eo); end
      if (eo) begin vectors++; if (ad !== ed) begin errors++; $display("FAIL bp_rel_data i=%0d got %h exp %h", i, ad, ed); end end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 320; i++) begin
      step(0, (i < 300) && ($urandom_range(0, 3) != 0), (i >= 300) || ($urandom_range(0, 2) != 0),
           er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== er) begin errors++; $display("FAIL rand_ready i=%0d got %b exp %b", i, ar, er); end
      vectors++; if (ao !== eo) begin errors++; $display("FAIL rand_valid i=%0d got %b exp %b", i, ao, eo); end
      if (eo) begin vectors++; if (ad !== ed) begin errors++; $display("FAIL rand_data i=%0d got %h exp %h", i, ad, ed); end end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, er, ar, eo, ao, ed, ad);
    do_reset(1);
`ifdef LATENCY_CREDIT_ADAPTER_PERF_EN
    #1;
    vectors++; if (a_perf !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d exp 0", a_perf); end
`endif
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 1'b1, er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== 1'b1) begin errors++; $display("FAIL midrst_ready i=%0d got %b exp 1", i, ar); end
      vectors++; if (ao !== 1'b0) begin errors++; $display("FAIL midrst_valid i=%0d got %b exp 0", i, ao); end
    end
  endtask

  task automatic test_depth1();
    for (int i = 0; i < 150; i++) begin
      step(1, (i < 40) || ((i < 140) && $urandom_range(0, 1) == 1),
           (i < 40) || (i >= 140) || ($urandom_range(0, 2) != 0), er, ar, eo, ao, ed, ad);
      vectors++; if (ar !== er) begin errors++; $display("FAIL d1_ready i=%0d got %b exp %b", i, ar, er); end
      vectors++; if (ao !== eo) begin errors++; $display("FAIL d1_valid i=%0d got %b exp %b", i, ao, eo); end
      if (eo) begin vectors++; if (ad !== ed) begin errors++; $display("FAIL d1_data i=%0d got %h exp %h", i, ad, ed); end end
    end
    vectors++; if (b_iss !== b_pop) begin errors++; $display("FAIL d1_delivered got %0d exp %0d", b_pop, b_iss); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_depth1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/latency_credit_adapter.md
LATENCY_CREDIT_ADAPTER -- requirements
Module: latency_credit_adapter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the pipe operands and result.
REQ-002 SHALL have parameter LATENCY, default 4, fixed issue-to-result latency in cycles of the attached no-stall pipe; legal range 2..16.
REQ-003 SHALL have parameter DEPTH, default 6, result FIFO entries and credit count; legal range 1..32.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a and in_b (input, WIDTH each): the upstream operand handshake.
REQ-007 SHALL have ports pipe_in1 and pipe_in2, output, WIDTH each: operands to the fixed-latency pipe.
REQ-008 SHALL have port pipe_out, input, WIDTH: the pipe result, valid exactly LATENCY cycles after issue.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, WIDTH): the downstream result handshake.

Function
REQ-010 SHALL define issue as in_valid && in_ready in a cycle; pipe_in1 = in_a and pipe_in2 = in_b combinationally in every cycle.
REQ-011 SHALL track issues in a LATENCY-deep valid shift register; a result tag SHALL reach the tail exactly LATENCY cycles after its issue cycle.
REQ-012 SHALL write pipe_out into the FIFO on the edge ending the cycle in which the tag is at the tail; non-tagged cycles SHALL write nothing (pipe data is don't-care then).
REQ-013 SHALL hold a credit counter (0..DEPTH): -1 on issue, +1 on pop (out_valid && out_ready), unchanged when both occur in one cycle.
REQ-014 SHALL drive in_ready = (credits != 0) from registered state only; a pop returns its credit from the next cycle.
REQ-015 SHALL guarantee FIFO never overflows: in-flight + stored <= DEPTH at all times.
REQ-016 SHALL drive out_valid = FIFO not empty; out_data = FIFO head, stable while out_valid && !out_ready.
REQ-017 SHALL allow FIFO write and pop in the same cycle at any occupancy, including empty (write visible next cycle) and full-minus-pop.
REQ-018 SHALL deliver results in issue order; minimum issue-to-out_valid latency LATENCY+1 cycles.
REQ-019 SHALL sustain one issue per cycle indefinitely when out_ready is held high and DEPTH >= LATENCY+2.
REQ-020 SHALL wrap FIFO read/write pointers modulo DEPTH for non-power-of-two DEPTH.

Reset
REQ-021 SHALL, while reset is high: clear the valid shift register, empty the FIFO, set credits = DEPTH; out_valid = 0 and in_ready = 1 in the first cycle after reset deasserts.
REQ-022 SHALL discard all in-flight and stored results on reset mid-operation; pipe results arriving after reset SHALL NOT be written.
REQ-023 SHALL ignore in_valid in any cycle where reset is high (no issue counted).

Configuration
REQ-024 SHALL, with macro LATENCY_CREDIT_ADAPTER_PERF_EN defined, add output perf_stall_cnt [31:0] counting cycles with in_valid && !in_ready, saturating at 0xFFFFFFFF, cleared by reset.
REQ-025 SHALL, without that macro, omit the port and counter entirely; all other behaviour identical.

Structure
REQ-026 SHALL place default WIDTH/LATENCY/DEPTH constants and a credit-width helper (clog2(DEPTH+1)) in shared package lca_pkg.
REQ-027 SHALL implement the FIFO as sub-module lca_fifo (synchronous, registered pointers, count output).

Verification
REQ-028 Single op: issue A at cycle 0, out_ready=1 -> pipe_out sampled at cycle 4, out_valid at cycle 5 with that value, credits back to 6.
REQ-029 Streaming: 100 back-to-back issues, out_ready=1 -> in_ready never drops, 100 results in order, zero gaps after first.
REQ-030 Backpressure: out_ready=0, in_valid=1 continuously -> exactly 6 issues, in_ready low from cycle 6, no FIFO overflow; release out_ready -> 6 results in order, issue resumes one cycle after first pop.
REQ-031 Simultaneous pop and issue at credits=0 boundary with DEPTH=1, LATENCY=2 -> credits alternates 1/0, every result delivered exactly once.
REQ-032 Reset mid-flight: 3 issued, reset one cycle at cycle 2 -> out_valid stays 0 for 10 cycles, credits=6, in_ready=1 after reset.
REQ-033 With LATENCY_CREDIT_ADAPTER_PERF_EN, 10 stalled cycles under REQ-030 stimulus -> perf_stall_cnt = 10; reset -> 0.
